// File: rtl/msrv32_wb_scheduler_if.sv
// Write-back scheduler bundle: execute stream, load issue/return, decode sources
// and the register-file write port. Master = pipeline side, slave = scheduler.
interface msrv32_wb_scheduler_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int LQ_DEPTH   = 2
);
  localparam int CW = $clog2(LQ_DEPTH) + 1;

  logic                  ex_wr_en_in;
  logic [ADDR_WIDTH-1:0] ex_rd_addr_in;
  logic [WIDTH-1:0]      ex_rd_in;
  logic                  ld_issue_in;
  logic [ADDR_WIDTH-1:0] ld_issue_addr_in;
  logic                  ld_valid_in;
  logic [ADDR_WIDTH-1:0] ld_ret_addr_in;
  logic [WIDTH-1:0]      ld_data_in;
  logic                  ld_ready_out;
  logic [ADDR_WIDTH-1:0] rs_1_addr_in;
  logic [ADDR_WIDTH-1:0] rs_2_addr_in;
  logic                  hazard_out;
  logic                  wr_en_out;
  logic [ADDR_WIDTH-1:0] wr_addr_out;
  logic [WIDTH-1:0]      wr_data_out;
  logic [CW-1:0]         lq_count_out;

  modport master (
    output ex_wr_en_in, ex_rd_addr_in, ex_rd_in,
    output ld_issue_in, ld_issue_addr_in,
    output ld_valid_in, ld_ret_addr_in, ld_data_in,
    output rs_1_addr_in, rs_2_addr_in,
    input  ld_ready_out, hazard_out,
    input  wr_en_out, wr_addr_out, wr_data_out, lq_count_out
  );

  modport slave (
    input  ex_wr_en_in, ex_rd_addr_in, ex_rd_in,
    input  ld_issue_in, ld_issue_addr_in,
    input  ld_valid_in, ld_ret_addr_in, ld_data_in,
    input  rs_1_addr_in, rs_2_addr_in,
    output ld_ready_out, hazard_out,
    output wr_en_out, wr_addr_out, wr_data_out, lq_count_out
  );
endinterface

// File: rtl/msrv32_wb_scheduler.sv
// Merges execute writes and queued load returns onto one register-file write port,
// with a pending-load scoreboard. MSRV32_LD_BYPASS_EN lets a load skip an empty queue.
module msrv32_wb_scheduler #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 32,
  parameter int LQ_DEPTH   = 2
) (
  input  logic                  msrv32_mp_clk_in,
  input  logic                  msrv32_mp_rst_in,
  msrv32_wb_scheduler_if.slave  io_wb
);
  localparam int PW = $clog2(LQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] LQ_FULL = CW'(LQ_DEPTH);

  logic [ADDR_WIDTH-1:0] r_lq_addr [LQ_DEPTH];
  logic [WIDTH-1:0]      r_lq_data [LQ_DEPTH];
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [CW-1:0]         r_count;
  logic [DEPTH-1:0]      r_sb;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [WIDTH-1:0]      r_wr_data;

  logic                  w_ready;
  logic                  w_accept;
  logic                  w_ex_req;
  logic                  w_q_nonempty;
  logic                  w_grant_q;
  logic                  w_grant_byp;
  logic                  w_push;
  logic                  w_pop;
  logic [ADDR_WIDTH-1:0] w_head_addr;
  logic [WIDTH-1:0]      w_head_data;
  logic                  w_ld_wr;
  logic [ADDR_WIDTH-1:0] w_ld_wr_addr;
  logic [DEPTH-1:0]      w_sb_next;

  // Ready comes from registered occupancy only, so a pop never raises it early.
  assign w_ready      = (r_count < LQ_FULL);
  assign w_accept     = io_wb.ld_valid_in && w_ready;
  assign w_ex_req     = io_wb.ex_wr_en_in && (io_wb.ex_rd_addr_in != '0);
  assign w_q_nonempty = (r_count != '0);
  assign w_grant_q    = !w_ex_req && w_q_nonempty;
`ifdef MSRV32_LD_BYPASS_EN
  assign w_grant_byp  = !w_ex_req && !w_q_nonempty && w_accept;
`else
  assign w_grant_byp  = 1'b0;
`endif
  assign w_push       = w_accept && !w_grant_byp;
  assign w_pop        = w_grant_q;
  assign w_head_addr  = r_lq_addr[r_head];
  assign w_head_data  = r_lq_data[r_head];

  always_comb begin
    w_ld_wr      = 1'b0;
    w_ld_wr_addr = '0;
    if (w_grant_q) begin
      w_ld_wr      = (w_head_addr != '0);
      w_ld_wr_addr = w_head_addr;
    end else if (w_grant_byp) begin
      w_ld_wr      = (io_wb.ld_ret_addr_in != '0);
      w_ld_wr_addr = io_wb.ld_ret_addr_in;
    end
  end

  // Clear first, then set, so a same-cycle reissue keeps the bit pending.
  always_comb begin
    w_sb_next = r_sb;
    if (w_ld_wr)
      w_sb_next[w_ld_wr_addr] = 1'b0;
    if (io_wb.ld_issue_in && (io_wb.ld_issue_addr_in != '0))
      w_sb_next[io_wb.ld_issue_addr_in] = 1'b1;
    w_sb_next[0] = 1'b0;
  end

  always_ff @(posedge msrv32_mp_clk_in) begin
    if (w_push) begin
      r_lq_addr[r_tail] <= io_wb.ld_ret_addr_in;
      r_lq_data[r_tail] <= io_wb.ld_data_in;
    end
  end

  always_ff @(posedge msrv32_mp_clk_in or posedge msrv32_mp_rst_in) begin
    if (msrv32_mp_rst_in) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_sb      <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      if (w_push)
        r_tail <= r_tail + PW'(1);
      if (w_pop)
        r_head <= r_head + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_sb <= w_sb_next;

      if (w_ex_req) begin
        r_wr_en   <= 1'b1;
        r_wr_addr <= io_wb.ex_rd_addr_in;
        r_wr_data <= io_wb.ex_rd_in;
      end else if (w_grant_q) begin
        r_wr_en   <= (w_head_addr != '0);
        r_wr_addr <= w_head_addr;
        r_wr_data <= w_head_data;
      end else if (w_grant_byp) begin
        r_wr_en   <= (io_wb.ld_ret_addr_in != '0);
        r_wr_addr <= io_wb.ld_ret_addr_in;
        r_wr_data <= io_wb.ld_data_in;
      end else begin
        r_wr_en   <= 1'b0;
      end
    end
  end

  assign io_wb.ld_ready_out = w_ready;
  assign io_wb.lq_count_out = r_count;
  assign io_wb.wr_en_out    = r_wr_en;
  assign io_wb.wr_addr_out  = r_wr_addr;
  assign io_wb.wr_data_out  = r_wr_data;
  assign io_wb.hazard_out   = r_sb[io_wb.rs_1_addr_in] || r_sb[io_wb.rs_2_addr_in] ||
                              (io_wb.ld_issue_in && r_sb[io_wb.ld_issue_addr_in]);
endmodule

// File: tb/tb_msrv32_wb_scheduler.sv
// Directed bench for msrv32_wb_scheduler: queue/scoreboard model checked every cycle
// plus hand-computed spot checks.
module tb_msrv32_wb_scheduler;
  localparam int W   = 32;
  localparam int AW  = 5;
  localparam int D   = 32;
  localparam int LQD = 2;
`ifdef MSRV32_LD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  msrv32_wb_scheduler_if #(.WIDTH(W), .ADDR_WIDTH(AW), .LQ_DEPTH(LQD)) bus ();

  msrv32_wb_scheduler #(.WIDTH(W), .ADDR_WIDTH(AW), .DEPTH(D), .LQ_DEPTH(LQD)) dut (
    .msrv32_mp_clk_in (clk),
    .msrv32_mp_rst_in (rst),
    .io_wb            (bus)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [W-1:0]  d;
  } ent_t;

  ent_t          mq[$];
  bit            msb [D];
  bit            m_en = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [W-1:0]  m_data = '0;
  int            n_chk = 0;
  int            n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference: FIFO of pending returns, set of pending registers, last granted write.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      for (int i = 0; i < D; i++) msb[i] = 1'b0;
      m_en = 1'b0; m_addr = '0; m_data = '0;
    end else begin
      bit   acc;
      bit   taken;
      int   clr;
      ent_t e;
      clr   = -1;
      taken = 1'b0;
      acc   = bus.ld_valid_in && (mq.size() < LQD);
      if (bus.ex_wr_en_in && bus.ex_rd_addr_in != 0) begin
        m_en = 1'b1; m_addr = bus.ex_rd_addr_in; m_data = bus.ex_rd_in;
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        m_en = (e.a != 0); m_addr = e.a; m_data = e.d; clr = int'(e.a);
      end else if (BYP && acc) begin
        m_en = (bus.ld_ret_addr_in != 0); m_addr = bus.ld_ret_addr_in;
        m_data = bus.ld_data_in; clr = int'(bus.ld_ret_addr_in); taken = 1'b1;
      end else begin
        m_en = 1'b0;
      end
      if (acc && !taken) begin
        e.a = bus.ld_ret_addr_in; e.d = bus.ld_data_in;
        mq.push_back(e);
      end
      if (clr > 0) msb[clr] = 1'b0;
      if (bus.ld_issue_in && bus.ld_issue_addr_in != 0) msb[bus.ld_issue_addr_in] = 1'b1;
    end
  end

  always @(negedge clk) begin
    #2;
    if (rst) begin
      chk("rst_wr_en", bus.wr_en_out, 0);
      chk("rst_wr_addr", bus.wr_addr_out, 0);
      chk("rst_wr_data", bus.wr_data_out, 0);
      chk("rst_lq_count", bus.lq_count_out, 0);
      chk("rst_ld_ready", bus.ld_ready_out, 1);
      chk("rst_hazard", bus.hazard_out, 0);
    end else begin
      chk("wr_en", bus.wr_en_out, m_en);
      if (m_en) begin
        chk("wr_addr", bus.wr_addr_out, m_addr);
        chk("wr_data", bus.wr_data_out, m_data);
        $display("WR x%0d <= %08h (t=%0t)", m_addr, m_data, $time);
      end
      chk("lq_count", bus.lq_count_out, mq.size());
      chk("ld_ready", bus.ld_ready_out, mq.size() < LQD);
      chk("hazard", bus.hazard_out, msb[bus.rs_1_addr_in] || msb[bus.rs_2_addr_in] ||
          (bus.ld_issue_in && msb[bus.ld_issue_addr_in]));
    end
  end

  task automatic idle_in();
    bus.ex_wr_en_in = 0; bus.ex_rd_addr_in = 0; bus.ex_rd_in = 0;
    bus.ld_issue_in = 0; bus.ld_issue_addr_in = 0;
    bus.ld_valid_in = 0; bus.ld_ret_addr_in = 0; bus.ld_data_in = 0;
    bus.rs_1_addr_in = 0; bus.rs_2_addr_in = 0;
  endtask

  task automatic cyc();
    @(negedge clk);
    idle_in();
  endtask

  task automatic issue(input logic [AW-1:0] a);
    bus.ld_issue_in = 1; bus.ld_issue_addr_in = a;
  endtask

  task automatic ret(input logic [AW-1:0] a, input logic [W-1:0] d);
    bus.ld_valid_in = 1; bus.ld_ret_addr_in = a; bus.ld_data_in = d;
  endtask

  task automatic ex(input logic [AW-1:0] a, input logic [W-1:0] d);
    bus.ex_wr_en_in = 1; bus.ex_rd_addr_in = a; bus.ex_rd_in = d;
  endtask

  initial begin
    int idx;
    idle_in();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #3;
    chk("lit_rst_ready", bus.ld_ready_out, 1);
    chk("lit_rst_count", bus.lq_count_out, 0);
    chk("lit_rst_wr_en", bus.wr_en_out, 0);

    cyc(); rst = 1'b0;
    ex(5, 32'hDEADBEEF);
    cyc(); ex(0, 32'h1111_1111); #3;
    chk("lit_ex_wr_en", bus.wr_en_out, 1);
    chk("lit_ex_addr", bus.wr_addr_out, 5);
    chk("lit_ex_data", bus.wr_data_out, 32'hDEADBEEF);
    cyc(); #3;
    chk("lit_ex_x0_wr_en", bus.wr_en_out, 0);

    // load to x7 with a dependent read
    cyc(); issue(7);
    cyc(); bus.rs_1_addr_in = 7; ret(7, 32'h12345678); #3;
    chk("lit_ld_hazard", bus.hazard_out, 1);
    cyc(); bus.rs_1_addr_in = 7; #3;
`ifdef MSRV32_LD_BYPASS_EN
    chk("lit_byp_wr_en", bus.wr_en_out, 1);
    chk("lit_byp_data", bus.wr_data_out, 32'h12345678);
    chk("lit_byp_hazard", bus.hazard_out, 0);
`else
    chk("lit_q_wr_en_early", bus.wr_en_out, 0);
    chk("lit_q_hazard_early", bus.hazard_out, 1);
    cyc(); bus.rs_1_addr_in = 7; #3;
    chk("lit_q_wr_en", bus.wr_en_out, 1);
    chk("lit_q_addr", bus.wr_addr_out, 7);
    chk("lit_q_data", bus.wr_data_out, 32'h12345678);
    chk("lit_q_hazard", bus.hazard_out, 0);
`endif

    // contention: 4 execute writes while 3 loads return
    cyc(); issue(10);
    cyc(); issue(11);
    cyc(); issue(12);
    idx = 0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (k < 4) ex(AW'(k + 1), 32'(100 + k));
      if (idx < 3) ret(AW'(10 + idx), 32'hA0 + 32'(idx));
      #1;
      if (bus.ld_valid_in && bus.ld_ready_out) idx++;
      #2;
      case (k)
        2: begin
          chk("lit_cont_ready", bus.ld_ready_out, 0);
          chk("lit_cont_count", bus.lq_count_out, 2);
        end
        4: chk("lit_cont_ex4", bus.wr_data_out, 103);
        5: begin
          chk("lit_cont_a0_addr", bus.wr_addr_out, 10);
          chk("lit_cont_a0_data", bus.wr_data_out, 32'hA0);
          chk("lit_cont_count5", bus.lq_count_out, 1);
        end
        6: chk("lit_cont_a1_addr", bus.wr_addr_out, 11);
        7: begin
          chk("lit_cont_a2_data", bus.wr_data_out, 32'hA2);
          chk("lit_cont_drained", bus.lq_count_out, 0);
        end
        default: ;
      endcase
    end

    // full queue, then pop and push/pop together
    cyc(); issue(20);
    cyc(); issue(21);
    idx = 0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      if (k < 2) ex(3, 32'(300 + k));
      if (idx < 3) ret(AW'(20 + idx), 32'hD0 + 32'(idx));
      #1;
      if (bus.ld_valid_in && bus.ld_ready_out) idx++;
      #2;
      case (k)
        2: begin
          chk("lit_pp_full_count", bus.lq_count_out, 2);
          chk("lit_pp_full_ready", bus.ld_ready_out, 0);
        end
        3: chk("lit_pp_d0", bus.wr_data_out, 32'hD0);
        4: begin
          chk("lit_pp_count", bus.lq_count_out, 1);
          chk("lit_pp_d1", bus.wr_data_out, 32'hD1);
        end
        5: chk("lit_pp_d2_addr", bus.wr_addr_out, 22);
        default: ;
      endcase
    end

    // scoreboard set/clear collision on x9
    cyc(); issue(9);
    cyc(); ret(9, 32'h99);
`ifdef MSRV32_LD_BYPASS_EN
    issue(9);
`else
    cyc(); issue(9);
`endif
    cyc(); bus.rs_2_addr_in = 9; #3;
    chk("lit_coll_wr_addr", bus.wr_addr_out, 9);
    chk("lit_coll_hazard", bus.hazard_out, 1);

    // load to x0
    cyc(); issue(0);
    cyc(); ret(0, 32'h55);
    cyc(); #3;
    chk("lit_x0_wr_en_a", bus.wr_en_out, 0);
    cyc(); #3;
    chk("lit_x0_wr_en_b", bus.wr_en_out, 0);
    chk("lit_x0_hazard", bus.hazard_out, 0);
    cyc(); bus.rs_2_addr_in = 9; #3;
    chk("lit_x9_still_pending", bus.hazard_out, 1);

    // reset in the middle of traffic
    cyc(); issue(15);
    cyc(); ex(3, 32'h77); ret(15, 32'hF0);
    cyc(); ex(4, 32'h78); ret(16, 32'hF1);
    cyc(); rst = 1'b1; bus.rs_1_addr_in = 15; #3;
    chk("lit_mid_rst_count", bus.lq_count_out, 0);
    chk("lit_mid_rst_ready", bus.ld_ready_out, 1);
    chk("lit_mid_rst_wr_en", bus.wr_en_out, 0);
    chk("lit_mid_rst_hazard", bus.hazard_out, 0);
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0;
    cyc(); bus.rs_1_addr_in = 15; #3;
    chk("lit_post_rst_hazard", bus.hazard_out, 0);
    chk("lit_post_rst_count", bus.lq_count_out, 0);
    cyc();
    #3;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
